// File: rtl/cos_series_ctrl.sv
// cos_series_ctrl: evaluates cos(x) by Horner's rule in x^2 using an external
// reciprocal-factorial table (cosLUT, Q0.16, addr 0 = 1/2!).
//
// Handshakes:
// - A request moves when in_valid && in_ready are both high on a rising edge.
// - A result moves when out_valid && out_ready are both high on a rising edge.
// - in_ready is high only in IDLE.
// - out_valid and y_out hold steady until the result is taken.
//
// A single 16x17 multiplier is shared: in SQUARE it forms x*x, and in MAC and
// FINAL it forms x2*acc. All products are truncated (>>16, no rounding).
module cos_series_ctrl #(
  parameter int TERMS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  output logic [2:0]  lut_addr,
  input  logic [15:0] lut_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y_out,
  output logic [2:0]  dbg_state,
  output logic [16:0] dbg_acc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SQUARE = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Highest coefficient address; Horner starts from the smallest term.
  localparam logic [2:0] LAST_ADDR = 3'(TERMS - 1);

  logic [2:0]  state;
  logic [15:0] x;
  logic [15:0] x2;
  logic [16:0] acc;

  logic [15:0] mul_a;
  logic [16:0] mul_b;
  logic [32:0] prod;
  logic [16:0] mul_res;
  logic [16:0] final_val;

  // Select shared multiplier operands: x*x while squaring, x2*acc otherwise.
  always_comb begin
    mul_a = x2;
    mul_b = acc;
    if (state == S_SQUARE) begin
      mul_a = x;
      mul_b = {1'b0, x};
    end
  end

  assign prod      = {17'b0, mul_a} * {16'b0, mul_b};
  assign mul_res   = 17'(prod >> 16);
  assign final_val = 17'h10000 - mul_res;

  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;
  assign dbg_acc   = acc;

  // Sequencer: latch request, square x, then run Horner steps down the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      x2        <= '0;
      acc       <= '0;
      lut_addr  <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x        <= x_in;
            lut_addr <= LAST_ADDR;
            state    <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          // x < 1, so x*x >> 16 always fits in 16 bits.
          x2    <= mul_res[15:0];
          state <= S_LOAD;
        end
        S_LOAD: begin
          acc <= {1'b0, lut_data};
          if (TERMS == 1) begin
            state <= S_FINAL;
          end else begin
            lut_addr <= lut_addr - 3'd1;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          // Non-negative: acc <= c[k+1] < c[k] and x2 < 1.
          acc <= {1'b0, lut_data} - mul_res;
          if (lut_addr == 3'd0) begin
            state <= S_FINAL;
          end else begin
            lut_addr <= lut_addr - 3'd1;
          end
        end
        S_FINAL: begin
          // 1 - x2*acc; the only step that can set acc[16] (x == 0 gives 1.0).
          acc       <= final_val;
          y_out     <= final_val[16:1];
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cos_series_ctrl.sv
// Bench for cos_series_ctrl. Two instances are used: TERMS=4 (main) and TERMS=1.
module tb_cos_series_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SQUARE = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x_in, lut_data, y_out;
  logic [2:0]  lut_addr, dbg_state;
  logic [16:0] dbg_acc;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0] x_in1, lut_data1, y_out1;
  logic [2:0]  lut_addr1, dbg_state1;
  logic [16:0] dbg_acc1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  longint      acc_t[$];

  // cosLUT contents: 1/2!, 1/4!, 1/6!, 1/8!, ... in Q0.16 (rounded).
  function automatic logic [15:0] lut_rom(input logic [2:0] a);
    case (a)
      3'd0:    return 16'h8000;
      3'd1:    return 16'h0AAB;
      3'd2:    return 16'h005B;
      3'd3:    return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

  assign lut_data  = lut_rom(lut_addr);
  assign lut_data1 = lut_rom(lut_addr1);

  cos_series_ctrl #(.TERMS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .lut_addr(lut_addr), .lut_data(lut_data),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .dbg_state(dbg_state), .dbg_acc(dbg_acc)
  );

  cos_series_ctrl #(.TERMS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .x_in(x_in1), .lut_addr(lut_addr1), .lut_data(lut_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .y_out(y_out1),
    .dbg_state(dbg_state1), .dbg_acc(dbg_acc1)
  );

  // ---------------- reference model ----------------
  function automatic logic [16:0] mulq(input logic [15:0] a, input logic [16:0] b);
    logic [32:0] p;
    p = {17'b0, a} * {16'b0, b};
    return 17'(p >> 16);
  endfunction

  function automatic logic [15:0] cos_model(input logic [15:0] xv, input int terms);
    logic [15:0] x2;
    logic [16:0] a;
    logic [16:0] sq;
    sq = mulq(xv, {1'b0, xv});
    x2 = sq[15:0];
    a  = {1'b0, lut_rom(3'(terms - 1))};
    for (int k = terms - 2; k >= 0; k--) a = {1'b0, lut_rom(3'(k))} - mulq(x2, a);
    a = 17'h10000 - mulq(x2, a);
    return a[16:1];
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accepted request, compare on accepted result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cos_model(x_in, 4));
        acc_t.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("sb_y_out", y_out, exp_q.pop_front());
      end
      if (dbg_state == S_MAC || dbg_state == S_FINAL)
        check_eq("no_underflow", dbg_acc[16], 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Call at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send4(input logic [15:0] xv);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    x_in = xv;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    check_eq("accept", ok, 1);
  endtask

  // Counts falling edges after the accepting edge until out_valid is seen.
  task automatic wait_valid4(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check_eq("out_valid_seen", out_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  tr_state[7] = '{S_SQUARE, S_LOAD, S_MAC, S_MAC, S_MAC, S_FINAL, S_DONE};
  logic [2:0]  tr_addr[7]  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
  logic [16:0] tr_acc[7]   = '{17'h0, 17'h0, 17'h00002, 17'h0005B, 17'h00A95, 17'h07D5B, 17'h0E0AA};
  logic [15:0] b2b_vec[6]  = '{16'h1000, 16'h2345, 16'hC000, 16'hFFFF, 16'h8000, 16'h0001};

  initial begin
    int lat;
    bit ok;
    in_valid = 0; x_in = 0; out_ready = 1;
    in_valid1 = 0; x_in1 = 0; out_ready1 = 1;

    // Reset values
    rst_n = 0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_y_out", y_out, 0);
    check_eq("rst_lut_addr", lut_addr, 0);
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_acc", dbg_acc, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // x = 0 -> 1.0, latency 7
    send4(16'h0000);
    wait_valid4(lat);
    check_eq("lat_x0", lat, 7);
    check_eq("y_x0", y_out, 16'h8000);
    @(posedge clk); #1;

    // x = 0.5: step-by-step trace of address, state and accumulator
    send4(16'h8000);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_eq($sformatf("trace_state_%0d", i), dbg_state, tr_state[i]);
      check_eq($sformatf("trace_addr_%0d", i), lut_addr, tr_addr[i]);
      if (i >= 2) check_eq($sformatf("trace_acc_%0d", i), dbg_acc, tr_acc[i]);
    end
    check_eq("y_x8000_valid", out_valid, 1);
    check_eq("y_x8000", y_out, 16'h7055);
    @(posedge clk); #1;

    // x = 1 - 2^-16 -> 0x4529
    send4(16'hFFFF);
    wait_valid4(lat);
    check_eq("y_xffff", y_out, 16'h4529);
    @(posedge clk); #1;

    // TERMS=1 instance: x = 0.5 -> 0x7000, latency 4
    @(negedge clk);
    check_eq("t1_in_ready", in_ready1, 1);
    @(posedge clk); #1 in_valid1 = 1; x_in1 = 16'h8000;
    @(posedge clk); #1 in_valid1 = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid1) break;
    end
    check_eq("t1_valid", out_valid1, 1);
    check_eq("t1_lat", lat, 4);
    check_eq("t1_y", y_out1, 16'h7000);
    @(posedge clk); #1;

    // Stall: result for x = 0.25 held for 10 clocks, new request ignored
    out_ready = 0;
    send4(16'h4000);
    wait_valid4(lat);
    check_eq("lat_stall", lat, 7);
    @(posedge clk); #1 in_valid = 1; x_in = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_y", y_out, 16'h7C05);
      check_eq("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("post_stall_state", dbg_state, S_IDLE);
    check_eq("post_stall_valid", out_valid, 0);
    check_eq("post_stall_sb_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // Reset during MAC aborts the run
    send4(16'hFFFF);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (dbg_state == S_MAC) ok = 1;
    end
    check_eq("reached_mac", ok, 1);
    rst_n = 0;
    #1;
    exp_q.delete();
    acc_t.delete();
    check_eq("abort_state", dbg_state, S_IDLE);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_y", y_out, 0);
    check_eq("abort_addr", lut_addr, 0);
    check_eq("abort_acc", dbg_acc, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    send4(16'h8000);
    wait_valid4(lat);
    check_eq("after_abort_lat", lat, 7);
    check_eq("after_abort_y", y_out, 16'h7055);
    @(posedge clk); #1;

    // Back-to-back with out_ready high: one accept every 8 clocks
    acc_t.delete();
    in_valid = 1;
    foreach (b2b_vec[k]) begin
      x_in = b2b_vec[k];
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          @(posedge clk);
          #1;
        end
      end
      check_eq("b2b_accept", ok, 1);
    end
    in_valid = 0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("b2b_drain", exp_q.size(), 0);
    check_eq("b2b_accepts", acc_t.size(), 6);
    for (int i = 1; i < acc_t.size(); i++)
      check_eq("b2b_spacing", 32'(acc_t[i] - acc_t[i-1]), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
